// File: rtl/rcv_pkg.sv
// Shared definitions for the receive framer: FSM states, f_ctrl field positions and CRC-32 constants.
package rcv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_TRUNC = 2'd2
   } rcv_state_e;

   localparam int unsigned LEN_W        = 12;
   localparam int unsigned CTRL_LEN_LSB = 0;
   localparam int unsigned CTRL_LEN_MSB = 11;
   localparam int unsigned CTRL_HIPRIO  = 12;
   localparam int unsigned CTRL_ERR     = 13;
   localparam int unsigned CTRL_RUNT    = 14;
   localparam int unsigned CTRL_OVS     = 15;
   localparam int unsigned CTRL_ABORT   = 16;
   localparam int unsigned CTRL_SEQ_LSB = 17;
   localparam int unsigned CTRL_SEQ_MSB = 19;
   localparam int unsigned CTRL_CRC     = 20;

   function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) r[i] = v[31 - i];
      return r;
   endfunction

   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC_POLY_REFL = bit_reverse32(CRC_POLY);
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/rcv_crc32_byte.sv
// Combinational reflected CRC-32 update for one byte (LSB first).
module rcv_crc32_byte
   import rcv_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   always_comb begin
      logic [31:0] w_c;
      w_c = i_crc ^ {24'd0, i_data};
      for (int unsigned i = 0; i < 8; i++)
         w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY_REFL) : (w_c >> 1);
      o_crc = w_c;
   end

endmodule

// File: rtl/rcv_frame_ctrl_gen.sv
// Receive framer: forwards SOF/EOF-delimited bytes and emits the 24-bit xmitTop control block.
// Define FRAME_CRC_CHK_EN to enable CRC-32 residue checking into f_ctrl[20].
module rcv_frame_ctrl_gen
   import rcv_pkg::*;
#(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic             rx_err,
   input  logic             rx_hi_prio,
   output logic [7:0]       f_data,
   output logic             f_rec_data_valid,
   output logic [23:0]      f_ctrl,
   output logic             f_rec_frame_valid,
   output logic             f_hi_priority,
   output logic [CNT_W-1:0] err_frame_cnt
);

   localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] L_MIN = LEN_W'(MIN_LEN);

   rcv_state_e       r_state, w_state_nx;
   logic [LEN_W-1:0] r_len, w_len_nx;
   logic             r_err_seen, w_err_seen_nx;
   logic             r_ovs, w_ovs_nx;
   logic [2:0]       r_seq;
   logic             w_hp_nx, w_fwd, w_close, w_abort;
   logic             w_runt, w_err, w_crc_bad;
   logic [23:0]      w_ctrl;

   always_comb begin
      w_state_nx    = r_state;
      w_len_nx      = r_len;
      w_err_seen_nx = r_err_seen;
      w_ovs_nx      = r_ovs;
      w_hp_nx       = f_hi_priority;
      w_fwd         = 1'b0;
      w_close       = 1'b0;
      w_abort       = 1'b0;
      unique case (r_state)
         ST_IDLE: if (rx_valid && rx_sof) begin
            w_fwd         = 1'b1;
            w_len_nx      = LEN_W'(1);
            w_err_seen_nx = rx_err;
            w_ovs_nx      = 1'b0;
            w_hp_nx       = rx_hi_prio;
            if (rx_eof) w_close    = 1'b1;
            else        w_state_nx = ST_RECV;
         end
         ST_RECV: if (rx_valid) begin
            if (rx_sof) begin
               w_close    = 1'b1;
               w_abort    = 1'b1;
               w_state_nx = ST_IDLE;
            end else if (r_len == L_MAX) begin
               // Any byte past MAX_LEN (EOF included) is dropped and marks oversize.
               w_ovs_nx = 1'b1;
               if (rx_eof) begin
                  w_close    = 1'b1;
                  w_state_nx = ST_IDLE;
               end else begin
                  w_state_nx = ST_TRUNC;
               end
            end else begin
               w_fwd         = 1'b1;
               w_len_nx      = r_len + LEN_W'(1);
               w_err_seen_nx = r_err_seen | rx_err;
               if (rx_eof) begin
                  w_close    = 1'b1;
                  w_state_nx = ST_IDLE;
               end
            end
         end
         ST_TRUNC: if (rx_valid && (rx_sof || rx_eof)) begin
            w_close    = 1'b1;
            w_abort    = rx_sof;
            w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

`ifdef FRAME_CRC_CHK_EN
   logic [31:0] r_crc, w_crc_cur, w_crc_nx;

   assign w_crc_cur = (r_state == ST_IDLE) ? CRC_INIT : r_crc;

   rcv_crc32_byte u_crc (
      .i_crc  (w_crc_cur),
      .i_data (rx_data),
      .o_crc  (w_crc_nx)
   );

   always_ff @(posedge clk_sys) begin
      if (reset)      r_crc <= CRC_INIT;
      else if (w_fwd) r_crc <= w_crc_nx;
   end

   // A non-aborted, non-oversize close always forwards its last byte, so w_crc_nx covers the FCS.
   assign w_crc_bad = w_close && !w_abort && !w_ovs_nx && (w_crc_nx != CRC_RESIDUE);
`else
   assign w_crc_bad = 1'b0;
`endif

   always_comb begin
      w_runt = (w_len_nx < L_MIN);
      w_err  = w_runt | w_ovs_nx | w_abort | w_crc_bad | w_err_seen_nx;
      w_ctrl = '0;
      w_ctrl[CTRL_LEN_MSB:CTRL_LEN_LSB] = w_len_nx;
      w_ctrl[CTRL_HIPRIO]               = w_hp_nx;
      w_ctrl[CTRL_ERR]                  = w_err;
      w_ctrl[CTRL_RUNT]                 = w_runt;
      w_ctrl[CTRL_OVS]                  = w_ovs_nx;
      w_ctrl[CTRL_ABORT]                = w_abort;
      w_ctrl[CTRL_SEQ_MSB:CTRL_SEQ_LSB] = r_seq;
      w_ctrl[CTRL_CRC]                  = w_crc_bad;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state           <= ST_IDLE;
         r_len             <= '0;
         r_err_seen        <= 1'b0;
         r_ovs             <= 1'b0;
         r_seq             <= '0;
         f_data            <= '0;
         f_rec_data_valid  <= 1'b0;
         f_ctrl            <= '0;
         f_rec_frame_valid <= 1'b0;
         f_hi_priority     <= 1'b0;
         err_frame_cnt     <= '0;
      end else begin
         r_state           <= w_state_nx;
         r_len             <= w_len_nx;
         r_err_seen        <= w_err_seen_nx;
         r_ovs             <= w_ovs_nx;
         f_hi_priority     <= w_hp_nx;
         f_rec_data_valid  <= w_fwd;
         f_rec_frame_valid <= w_close;
         if (w_fwd) f_data <= rx_data;
         if (w_close) begin
            f_ctrl <= w_ctrl;
            r_seq  <= r_seq + 3'd1;
            if (w_err && (err_frame_cnt != '1)) err_frame_cnt <= err_frame_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rcv_frame_ctrl_gen.sv
// Self-checking bench for rcv_frame_ctrl_gen: frame-level reference model plus directed literal checks.
module tb_rcv_frame_ctrl_gen;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam int CNT_W   = 16;
`ifdef FRAME_CRC_CHK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic             clk_sys = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       rx_data = '0;
   logic             rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, rx_err = 1'b0, rx_hi_prio = 1'b0;
   logic [7:0]       f_data;
   logic             f_rec_data_valid, f_rec_frame_valid, f_hi_priority;
   logic [23:0]      f_ctrl;
   logic [CNT_W-1:0] err_frame_cnt;

   always #5 clk_sys = ~clk_sys;

   rcv_frame_ctrl_gen #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk_sys(clk_sys), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err), .rx_hi_prio(rx_hi_prio),
      .f_data(f_data), .f_rec_data_valid(f_rec_data_valid), .f_ctrl(f_ctrl),
      .f_rec_frame_valid(f_rec_frame_valid), .f_hi_priority(f_hi_priority),
      .err_frame_cnt(err_frame_cnt)
   );

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] v;
      v = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      return v;
   endfunction

   // ---------------- reference model: frame kept as a byte queue ----------------
   bit          m_in;
   logic [7:0]  m_q[$];
   bit          m_rxerr;
   int          m_seq;
   bit          exp_dv, exp_fv, exp_hp;
   logic [7:0]  exp_data;
   logic [23:0] exp_ctrl;
   int          exp_cnt;

   task automatic m_close(input bit ab);
      int n; bit ovs, runt, cbad, err; logic [31:0] c;
      ovs  = (m_q.size() > MAX_LEN);
      n    = ovs ? MAX_LEN : m_q.size();
      runt = (n < MIN_LEN);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) c = crc_upd(c, m_q[i]);
      cbad = CRC_EN && !ab && !ovs && (c != 32'hDEBB20E3);
      err  = runt | ovs | ab | cbad | m_rxerr;
      exp_ctrl = 24'(n + (int'(exp_hp) << 12) + (int'(err) << 13) + (int'(runt) << 14)
                 + (int'(ovs) << 15) + (int'(ab) << 16) + (m_seq << 17) + (int'(cbad) << 20));
      exp_fv = 1'b1;
      m_seq  = (m_seq + 1) % 8;
      if (err && exp_cnt != (1 << CNT_W) - 1) exp_cnt++;
      m_in = 1'b0;
   endtask

   always @(posedge clk_sys) begin
      exp_dv = 1'b0;
      exp_fv = 1'b0;
      if (reset) begin
         m_in = 1'b0; m_q.delete(); m_rxerr = 1'b0; m_seq = 0;
         exp_data = '0; exp_ctrl = '0; exp_hp = 1'b0; exp_cnt = 0;
      end else if (rx_valid) begin
         if (!m_in) begin
            if (rx_sof) begin
               m_in = 1'b1; m_q.delete(); m_q.push_back(rx_data);
               m_rxerr = rx_err; exp_hp = rx_hi_prio; exp_dv = 1'b1; exp_data = rx_data;
               if (rx_eof) m_close(1'b0);
            end
         end else if (rx_sof) begin
            m_close(1'b1);
         end else begin
            m_q.push_back(rx_data);
            if (m_q.size() <= MAX_LEN) begin
               exp_dv = 1'b1; exp_data = rx_data; m_rxerr |= rx_err;
            end
            if (rx_eof) m_close(1'b0);
         end
      end
   end

   // ---------------- compare process (sole owner of counters) ----------------
   int          checks = 0, failures = 0;
   bit          cmp_en = 1'b0;
   int          dcnt = 0, ccnt = 0;
   logic [23:0] ctrl_hist[$];
   int          pin_seq = 0, pin_done = 0;
   string       pin_name;
   logic [31:0] pin_act, pin_exp;

   function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
      end
   endfunction

   always @(negedge clk_sys) begin
      if (cmp_en) begin
         chk("data_valid", 32'(f_rec_data_valid), 32'(exp_dv));
         if (exp_dv) chk("data", 32'(f_data), 32'(exp_data));
         chk("frame_valid", 32'(f_rec_frame_valid), 32'(exp_fv));
         chk("ctrl", 32'(f_ctrl), 32'(exp_ctrl));
         chk("hi_prio", 32'(f_hi_priority), 32'(exp_hp));
         chk("err_cnt", 32'(err_frame_cnt), 32'(exp_cnt));
      end
      if (f_rec_data_valid) dcnt++;
      if (f_rec_frame_valid) begin ccnt++; ctrl_hist.push_back(f_ctrl); end
      if (pin_seq != pin_done) begin
         chk(pin_name, pin_act, pin_exp);
         pin_done = pin_seq;
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] tx_q[$];

   task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] e);
      pin_name = nm; pin_act = a; pin_exp = e; pin_seq++;
      @(negedge clk_sys);
      @(negedge clk_sys);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_sys);
         rx_valid = 1'b0; rx_data = 8'($urandom);
         rx_sof = 1'($urandom); rx_eof = 1'($urandom); rx_err = 1'($urandom); rx_hi_prio = 1'($urandom);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input bit sof, input bit eof, input bit err, input bit hp);
      @(negedge clk_sys);
      rx_valid = 1'b1; rx_data = d; rx_sof = sof; rx_eof = eof; rx_err = err;
      rx_hi_prio = sof ? hp : 1'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      reset = 1'b1; rx_valid = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
   endtask

   task automatic build_frame(input int len, input bit good_fcs);
      logic [31:0] c;
      tx_q.delete();
      if (good_fcs && len >= 5) begin
         c = 32'hFFFFFFFF;
         for (int i = 0; i < len - 4; i++) begin
            tx_q.push_back(8'($urandom));
            c = crc_upd(c, tx_q[i]);
         end
         c = ~c;
         for (int i = 0; i < 4; i++) tx_q.push_back(8'(c >> (8 * i)));
      end else begin
         for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
      end
   endtask

   // Sends tx_q[0 .. n-1]; EOF on the last only when eof_last.
   task automatic send_q(input int n, input bit hp, input bit eof_last, input int gap_pct, input int err_pct);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
         send_byte(tx_q[i], i == 0, eof_last && (i == n - 1), $urandom_range(0, 99) < err_pct, hp);
      end
   endtask

   int bd, bc;
   int lens_tbl[11] = '{1, 2, 10, 63, 64, 65, 1517, 1518, 1519, 1520, 1530};

   initial begin
      do_reset();
      cmp_en = 1'b1;

      // 1: 512-byte hi-prio frame, no gaps
      bd = dcnt; bc = ccnt;
      build_frame(512, 1'b1); send_q(512, 1'b1, 1'b1, 0, 0); idle(3);
      pin("t1_ndata", 32'(dcnt - bd), 32'd512);
      pin("t1_nctrl", 32'(ccnt - bc), 32'd1);
      pin("t1_ctrl", 32'(ctrl_hist[bc]), 32'h001200);

      // 2: runt then back-to-back 64-byte frame
      do_reset();
      bc = ccnt;
      build_frame(10, 1'b1); send_q(10, 1'b0, 1'b1, 0, 0);
      build_frame(64, 1'b1); send_q(64, 1'b0, 1'b1, 0, 0); idle(3);
      pin("t2_ctrl_a", 32'(ctrl_hist[bc]), 32'h00600A);
      pin("t2_ctrl_b", 32'(ctrl_hist[bc + 1]), 32'h020040);
      pin("t2_errcnt", 32'(err_frame_cnt), 32'd1);

      // 3: 1600-byte frame truncated at MAX_LEN
      do_reset();
      bd = dcnt; bc = ccnt;
      build_frame(1600, 1'b0); send_q(1600, 1'b0, 1'b1, 0, 0); idle(3);
      pin("t3_ndata", 32'(dcnt - bd), 32'd1518);
      pin("t3_ctrl", 32'(ctrl_hist[bc]), 32'h00A5EE);

      // 4: SOF arrives as byte 101 of an open frame; trailing bytes ignored
      do_reset();
      bd = dcnt; bc = ccnt;
      build_frame(100, 1'b0); send_q(100, 1'b0, 1'b0, 0, 0);
      send_byte(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0, (i % 7) == 6, 1'b0, 1'b0);
      idle(3);
      pin("t4_ndata", 32'(dcnt - bd), 32'd100);
      pin("t4_nctrl", 32'(ccnt - bc), 32'd1);
      pin("t4_ctrl", 32'(ctrl_hist[bc]), 32'h012064);

      // 5: reset mid-frame (no reset beforehand so outputs are non-zero going in)
      bc = ccnt;
      build_frame(80, 1'b1); send_q(50, 1'b1, 1'b0, 0, 0);
      @(negedge clk_sys); reset = 1'b1; rx_valid = 1'b0;
      @(negedge clk_sys);
      pin("t5_outs_in_reset", {f_hi_priority, f_rec_frame_valid, f_rec_data_valid, 5'd0, f_ctrl}, 32'd0);
      pin("t5_cnt_in_reset", 32'(err_frame_cnt), 32'd0);
      reset = 1'b0;
      idle(2);
      pin("t5_nctrl", 32'(ccnt - bc), 32'd0);
      build_frame(64, 1'b1); send_q(64, 1'b0, 1'b1, 0, 0); idle(3);
      pin("t5_ctrl", 32'(ctrl_hist[bc]), 32'h000040);

`ifdef FRAME_CRC_CHK_EN
      // 6: valid FCS, then same frame with one payload bit flipped
      do_reset();
      bc = ccnt;
      build_frame(64, 1'b1); send_q(64, 1'b0, 1'b1, 0, 0); idle(2);
      tx_q[20] = tx_q[20] ^ 8'h08; send_q(64, 1'b0, 1'b1, 0, 0); idle(3);
      pin("t6_ctrl_good", 32'(ctrl_hist[bc]), 32'h000040);
      pin("t6_ctrl_bad", 32'(ctrl_hist[bc + 1]), 32'h122040);
`endif

      // Randomized traffic: gaps, errors, aborts, truncation, junk bytes, mid-frame resets
      for (int f = 0; f < 80; f++) begin
         int len, kind, cut;
         bit hp;
         len  = ($urandom_range(0, 3) == 0) ? lens_tbl[$urandom_range(0, 10)] : $urandom_range(1, 200);
         kind = $urandom_range(0, 9);
         hp   = 1'($urandom);
         build_frame(len, $urandom_range(0, 3) != 0);
         if (kind == 0) begin
            cut = $urandom_range(1, len);
            send_q(cut, hp, 1'b0, 20, 2);
            send_byte(8'($urandom), 1'b1, 1'($urandom), 1'b0, 1'($urandom));
         end else if (kind == 1) begin
            cut = $urandom_range(1, len);
            send_q(cut, hp, 1'b0, 20, 0);
            do_reset();
         end else begin
            send_q(len, hp, 1'b1, (kind > 6) ? 25 : 0, 1);
         end
         repeat ($urandom_range(0, 2)) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            else idle(1);
         end
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
